// File: rtl/tristate_buf_led.sv
// Two-channel DIP-enabled tristate buffer for SPI MISO return lines, with LED status.
// Each DIP switch is synchronised and debounced before it gates its channel onto the shared line.
module tristate_buf_led #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 8
) (
  input  logic SYSCLK,
  input  logic SYSRESET,
  input  logic dip1,
  input  logic dip2,
  input  logic miso1_in,
  input  logic miso2_in,
  output wire  miso1,
  output wire  miso2,
  output logic led1,
  output logic led2
);

  localparam int unsigned NCH = 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NCH-1:0]            dip_c;
  logic [NCH-1:0]            s1_q;
  logic [NCH-1:0]            s2_q;
  logic [NCH-1:0]            en_q;
  logic [NCH-1:0]            en_d;
  logic [NCH-1:0]            led_q;
  logic [NCH-1:0][CNT_W-1:0] cnt_q;
  logic [NCH-1:0][CNT_W-1:0] cnt_d;

  assign dip_c = {dip2, dip1};

  // Debounce: a synced level must disagree with en for DEBOUNCE_CYCLES edges before it is taken.
  always_comb begin
    en_d  = en_q;
    cnt_d = '0;
    for (int i = 0; i < NCH; i++) begin
      if (s2_q[i] != en_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          en_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge SYSCLK or posedge SYSRESET) begin
    if (SYSRESET) begin
      s1_q  <= '0;
      s2_q  <= '0;
      en_q  <= '0;
      led_q <= '0;
      cnt_q <= '0;
    end else begin
      s1_q  <= dip_c;
      s2_q  <= s1_q;
      en_q  <= en_d;
      led_q <= en_q;
      cnt_q <= cnt_d;
    end
  end

  // Data path is purely combinational so MISO sees no added latency while enabled.
  assign miso1 = en_q[0] ? miso1_in : 1'bz;
  assign miso2 = en_q[1] ? miso2_in : 1'bz;

  assign led1 = led_q[0];
  assign led2 = led_q[1];

endmodule

// File: tb/tb_tristate_buf_led.sv
// Directed bench for tristate_buf_led: expected outputs are queued as stimulus is applied
// and popped as each edge is sampled. miso1 is pulled up and miso2 pulled down so a released line is visible.
`timescale 1ns/1ps
module tb_tristate_buf_led;

  logic SYSCLK = 1'b0;
  logic SYSRESET;
  logic dip1, dip2, miso1_in, miso2_in;
  wire  miso1, miso2;
  logic led1, led2;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    string tag;
    logic  m1;
    logic  m2;
    logic  l1;
    logic  l2;
  } exp_t;

  exp_t sb[$];

  pullup   (miso1);
  pulldown (miso2);

  tristate_buf_led #(.DEBOUNCE_CYCLES(4), .CNT_W(8)) dut (
    .SYSCLK   (SYSCLK),
    .SYSRESET (SYSRESET),
    .dip1     (dip1),
    .dip2     (dip2),
    .miso1_in (miso1_in),
    .miso2_in (miso2_in),
    .miso1    (miso1),
    .miso2    (miso2),
    .led1     (led1),
    .led2     (led2)
  );

  always #12.5 SYSCLK = ~SYSCLK;

  task automatic step();
    @(posedge SYSCLK);
    #1;
  endtask

  task automatic push(input string tag, input logic m1, input logic m2, input logic l1, input logic l2);
    exp_t e;
    e.tag = tag; e.m1 = m1; e.m2 = m2; e.l1 = l1; e.l2 = l2;
    sb.push_back(e);
  endtask

  task automatic cmp(input string tag, input string sig, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s.%s observed=%b expected=%b", tag, sig, obs, exp);
    end
  endtask

  task automatic check_now();
    exp_t e;
    tests++;
    assert (sb.size() > 0) else begin
      failed++;
      $error("FAIL scoreboard_underflow observed=empty expected=entry");
      return;
    end
    e = sb.pop_front();
    cmp(e.tag, "miso1", miso1, e.m1);
    cmp(e.tag, "miso2", miso2, e.m2);
    cmp(e.tag, "led1",  led1,  e.l1);
    cmp(e.tag, "led2",  led2,  e.l2);
  endtask

  initial begin
    SYSRESET = 1'b1;
    dip1 = 1'b0; dip2 = 1'b0; miso1_in = 1'b0; miso2_in = 1'b0;

    // 1: reset state, then holds after release
    repeat (2) step();
    push("reset", 1'b1, 1'b0, 1'b0, 1'b0);
    check_now();
    SYSRESET = 1'b0;
    repeat (3) step();
    push("post_reset", 1'b1, 1'b0, 1'b0, 1'b0);
    check_now();

    // 2: dip1 held high; miso1 released for 5 edges, drives from edge 6, led1 from edge 7
    dip1 = 1'b1; miso1_in = 1'b0;
    for (int k = 1; k <= 5; k++) push($sformatf("en1_edge%0d", k), 1'b1, 1'b0, 1'b0, 1'b0);
    push("en1_edge6", 1'b0, 1'b0, 1'b0, 1'b0);
    push("en1_edge7", 1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 7; k++) begin step(); check_now(); end
    miso1_in = 1'b1; #1;
    push("toggle_hi", 1'b1, 1'b0, 1'b1, 1'b0);
    check_now();
    miso1_in = 1'b0; #1;
    push("toggle_lo", 1'b0, 1'b0, 1'b1, 1'b0);
    check_now();

    // 3: 2-cycle dip2 glitch never enables channel 2
    step();
    miso2_in = 1'b1; dip2 = 1'b1;
    for (int k = 1; k <= 12; k++) push($sformatf("glitch2_edge%0d", k), 1'b0, 1'b0, 1'b1, 1'b0);
    step(); check_now();
    step(); check_now();
    dip2 = 1'b0;
    for (int k = 3; k <= 12; k++) begin step(); check_now(); end

    // 4: enable channel 2, then drop dip1 while channel 2 keeps driving
    dip2 = 1'b1;
    for (int k = 1; k <= 5; k++) push($sformatf("en2_edge%0d", k), 1'b0, 1'b0, 1'b1, 1'b0);
    push("en2_edge6", 1'b0, 1'b1, 1'b1, 1'b0);
    push("en2_edge7", 1'b0, 1'b1, 1'b1, 1'b1);
    for (int k = 1; k <= 7; k++) begin step(); check_now(); end
    dip1 = 1'b0;
    for (int k = 1; k <= 5; k++) push($sformatf("dis1_edge%0d", k), 1'b0, 1'b1, 1'b1, 1'b1);
    push("dis1_edge6", 1'b1, 1'b1, 1'b1, 1'b1);
    push("dis1_edge7", 1'b1, 1'b1, 1'b0, 1'b1);
    for (int k = 1; k <= 7; k++) begin step(); check_now(); end

    // 5: re-enable channel 1, then asynchronous reset mid-cycle
    dip1 = 1'b1;
    repeat (7) step();
    push("pre_async_rst", 1'b0, 1'b1, 1'b1, 1'b1);
    check_now();
    @(posedge SYSCLK);
    #6;
    SYSRESET = 1'b1;
    #1;
    push("async_rst", 1'b1, 1'b0, 1'b0, 1'b0);
    check_now();
    dip1 = 1'b0; dip2 = 1'b0;
    repeat (2) step();
    SYSRESET = 1'b0;
    repeat (8) step();
    push("after_async_rst", 1'b1, 1'b0, 1'b0, 1'b0);
    check_now();

    // 6: simultaneous enable of both channels lands on the same edge
    dip1 = 1'b1; dip2 = 1'b1; miso1_in = 1'b0; miso2_in = 1'b1;
    for (int k = 1; k <= 5; k++) push($sformatf("both_edge%0d", k), 1'b1, 1'b0, 1'b0, 1'b0);
    push("both_edge6", 1'b0, 1'b1, 1'b0, 1'b0);
    push("both_edge7", 1'b0, 1'b1, 1'b1, 1'b1);
    for (int k = 1; k <= 7; k++) begin step(); check_now(); end

    tests++;
    assert (sb.size() == 0) else begin
      failed++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
